// File: rtl/uart_pkg.sv
// Shared UART definitions used by the u_rec receiver and u_xmit transmitter.
package uart_pkg;

    localparam int unsigned WORD_LEN   = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam logic        LO         = 1'b0;
    localparam logic        HI         = 1'b1;

    typedef enum logic [2:0] {
        r_IDLE,
        r_CENTER,
        r_WAIT,
        r_SAMPLE,
        r_STOP,
        r_BREAK
    } recState_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/u_rec_sync.sv
// Two-flop synchronizer for the asynchronous serial line; synchronous reset to RST_VAL.
module u_rec_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic asyncIn,
    output logic syncOut
);

    logic meta;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            meta    <= RST_VAL;
            syncOut <= RST_VAL;
        end else begin
            meta    <= asyncIn;
            syncOut <= meta;
        end
    end

endmodule

// File: rtl/u_rec.sv
// 16x-oversampling 8N1 UART receiver with ready/ack handshake, framing and overrun status.
// Optional build macro UART_MAJORITY_VOTE_EN: 2-of-3 vote for each data/stop bit decision.
module u_rec
    import uart_pkg::*;
#(
    parameter int unsigned WORD_LEN   = uart_pkg::WORD_LEN,
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                uart_recH,
    input  logic                rec_ackH,
    output logic [WORD_LEN-1:0] rec_dataH,
    output logic                rec_readyH,
    output logic                rec_busyH,
    output logic                frame_errH,
    output logic                overrun_errH
);

    localparam logic [4:0] CENTER_LAST = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0] WAIT_LAST   = 5'(OVERSAMPLE - 2);
    localparam logic [3:0] LAST_BIT    = 4'(WORD_LEN);

    recState_t             state, nextState;
    logic [4:0]            bitCell;
    logic [3:0]            bitCount;
    logic [WORD_LEN-1:0]   shiftReg;
    logic                  cellInc;
    logic                  rx_s;
    logic                  bitVal;
    logic                  ackTaken;

    u_rec_sync #(.RST_VAL(1'b1)) uSync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .asyncIn (uart_recH),
        .syncOut (rx_s)
    );

`ifdef UART_MAJORITY_VOTE_EN
    logic vote13, vote14;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vote13 <= 1'b0;
            vote14 <= 1'b0;
        end else if (state == r_WAIT) begin
            if (bitCell == WAIT_LAST - 5'd1) vote13 <= rx_s;
            if (bitCell == WAIT_LAST)        vote14 <= rx_s;
        end
    end

    assign bitVal = majority3(vote13, vote14, rx_s);
`else
    assign bitVal = rx_s;
`endif

    always_comb begin
        nextState = state;
        cellInc   = 1'b0;
        case (state)
            r_IDLE:   if (rx_s == LO) nextState = r_CENTER;
            r_CENTER: begin
                if (rx_s == HI)                nextState = r_IDLE;
                else if (bitCell == CENTER_LAST) nextState = r_WAIT;
                else                           cellInc   = 1'b1;
            end
            r_WAIT: begin
                if (bitCell == WAIT_LAST) nextState = (bitCount == LAST_BIT) ? r_STOP : r_SAMPLE;
                else                      cellInc   = 1'b1;
            end
            r_SAMPLE: nextState = r_WAIT;
            r_STOP:   nextState = (rx_s == HI) ? r_IDLE : r_BREAK;
            r_BREAK:  if (rx_s == HI) nextState = r_IDLE;
            default:  nextState = r_IDLE;
        endcase
    end

    assign rec_busyH = (state != r_IDLE);
    assign ackTaken  = rec_ackH & rec_readyH;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= r_IDLE;
            bitCell      <= '0;
            bitCount     <= '0;
            shiftReg     <= '0;
            rec_dataH    <= '0;
            rec_readyH   <= 1'b0;
            frame_errH   <= 1'b0;
            overrun_errH <= 1'b0;
        end else begin
            state   <= nextState;
            bitCell <= cellInc ? bitCell + 5'd1 : '0;

            if (state == r_IDLE)        bitCount <= '0;
            else if (state == r_SAMPLE) bitCount <= bitCount + 4'd1;

            if (state == r_SAMPLE) shiftReg <= {bitVal, shiftReg[WORD_LEN-1:1]};

            // A completing frame beats a simultaneous ack: ready stays set and the
            // ack only clears overrun history, it never flags a new overrun.
            if (state == r_STOP) begin
                rec_dataH    <= shiftReg;
                frame_errH   <= ~bitVal;
                rec_readyH   <= 1'b1;
                overrun_errH <= (overrun_errH & ~ackTaken) | (rec_readyH & ~rec_ackH);
            end else if (ackTaken) begin
                rec_readyH   <= 1'b0;
                overrun_errH <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_u_rec.sv
// Directed self-checking bench for the u_rec UART receiver.
module tb_u_rec;

    logic       sys_clk   = 1'b0;
    logic       sys_rst   = 1'b1;
    logic       uart_recH = 1'b1;
    logic       rec_ackH  = 1'b0;
    logic [7:0] rec_dataH;
    logic       rec_readyH;
    logic       rec_busyH;
    logic       frame_errH;
    logic       overrun_errH;

    int unsigned tests = 0;
    int unsigned fails = 0;

    int unsigned cyc = 0;
    int unsigned startCyc = 0;
    int unsigned riseCyc = 0;
    int unsigned riseCount = 0;
    logic        prevReady = 1'b0;

    u_rec #(.WORD_LEN(8), .OVERSAMPLE(16)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .uart_recH    (uart_recH),
        .rec_ackH     (rec_ackH),
        .rec_dataH    (rec_dataH),
        .rec_readyH   (rec_readyH),
        .rec_busyH    (rec_busyH),
        .frame_errH   (frame_errH),
        .overrun_errH (overrun_errH)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (rec_readyH && !prevReady) begin
            riseCount <= riseCount + 1;
            riseCyc   <= cyc;
        end
        prevReady <= rec_readyH;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Line edges are driven on the falling clock edge; bit k of the frame is
    // captured by the receiver starting 16*(k+1) rising edges after the start bit.
    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic spike);
        @(negedge sys_clk);
        uart_recH = 1'b0;
        startCyc  = cyc + 1;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_recH = d[i];
            if (spike) begin
                repeat (8) @(negedge sys_clk);
                uart_recH = 1'b1;
                @(negedge sys_clk);
                uart_recH = d[i];
                repeat (7) @(negedge sys_clk);
            end else begin
                repeat (16) @(negedge sys_clk);
            end
        end
        uart_recH = stopBit;
        repeat (16) @(negedge sys_clk);
        uart_recH = 1'b1;
    endtask

    task automatic pulseAck();
        rec_ackH = 1'b1;
        @(negedge sys_clk);
        rec_ackH = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (4) @(negedge sys_clk);
        tests++; if (rec_dataH !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", rec_dataH); end
        tests++; if (rec_readyH !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", rec_readyH); end
        tests++; if (rec_busyH !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", rec_busyH); end
        tests++; if (frame_errH !== 1'b0 || overrun_errH !== 1'b0) begin
            fails++; $display("FAIL reset_err: got frame=%b overrun=%b want 0/0", frame_errH, overrun_errH);
        end
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_basic();
        int unsigned base;
        int unsigned lat;
        base = riseCount;
        sendFrame(8'hA5, 1'b1, 1'b0);
        lat = riseCyc - startCyc;
        tests++; if (riseCount !== base + 1) begin fails++; $display("FAIL basic_rise: got %0d rises want 1", riseCount - base); end
        tests++; if (lat < 150 || lat > 158) begin fails++; $display("FAIL basic_latency: got %0d want 150..158", lat); end
        tests++; if (rec_dataH !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", rec_dataH); end
        tests++; if (rec_readyH !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b want 1", rec_readyH); end
        tests++; if (frame_errH !== 1'b0 || overrun_errH !== 1'b0) begin
            fails++; $display("FAIL basic_err: got frame=%b overrun=%b want 0/0", frame_errH, overrun_errH);
        end
        tests++; if (rec_busyH !== 1'b0) begin fails++; $display("FAIL basic_idle: got busy %b want 0", rec_busyH); end
        pulseAck();
        tests++; if (rec_readyH !== 1'b0) begin fails++; $display("FAIL basic_ack: got ready %b want 0", rec_readyH); end
        tests++; if (rec_dataH !== 8'hA5) begin fails++; $display("FAIL basic_hold: got %h want a5", rec_dataH); end
    endtask

    task automatic test_glitch();
        int unsigned busyCycles = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge sys_clk);
            if (k == 0) uart_recH = 1'b0;
            if (k == 5) uart_recH = 1'b1;
            if (rec_busyH) busyCycles++;
        end
        tests++; if (busyCycles < 1 || busyCycles > 8) begin fails++; $display("FAIL glitch_busy: got %0d cycles want 1..8", busyCycles); end
        tests++; if (rec_readyH !== 1'b0) begin fails++; $display("FAIL glitch_ready: got %b want 0", rec_readyH); end
        tests++; if (rec_busyH !== 1'b0) begin fails++; $display("FAIL glitch_idle: got busy %b want 0", rec_busyH); end
    endtask

    task automatic test_framing();
        sendFrame(8'h3C, 1'b0, 1'b0);
        tests++; if (rec_dataH !== 8'h3C) begin fails++; $display("FAIL frame_data: got %h want 3c", rec_dataH); end
        tests++; if (frame_errH !== 1'b1) begin fails++; $display("FAIL frame_err: got %b want 1", frame_errH); end
        tests++; if (rec_busyH !== 1'b1) begin fails++; $display("FAIL frame_break: got busy %b want 1", rec_busyH); end
        repeat (3) @(negedge sys_clk);
        tests++; if (rec_busyH !== 1'b0) begin fails++; $display("FAIL frame_break_exit: got busy %b want 0", rec_busyH); end
        pulseAck();
        sendFrame(8'h81, 1'b1, 1'b0);
        tests++; if (rec_dataH !== 8'h81) begin fails++; $display("FAIL frame_next_data: got %h want 81", rec_dataH); end
        tests++; if (frame_errH !== 1'b0) begin fails++; $display("FAIL frame_next_err: got %b want 0", frame_errH); end
        pulseAck();
    endtask

    task automatic test_overrun();
        int unsigned tgt;
        sendFrame(8'h11, 1'b1, 1'b0);
        sendFrame(8'h22, 1'b1, 1'b0);
        tests++; if (rec_dataH !== 8'h22) begin fails++; $display("FAIL ovr_data: got %h want 22", rec_dataH); end
        tests++; if (overrun_errH !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", overrun_errH); end
        pulseAck();
        tests++; if (rec_readyH !== 1'b0 || overrun_errH !== 1'b0) begin
            fails++; $display("FAIL ovr_clear: got ready=%b overrun=%b want 0/0", rec_readyH, overrun_errH);
        end
        pulseAck();
        tests++; if (rec_readyH !== 1'b0 || overrun_errH !== 1'b0) begin
            fails++; $display("FAIL ovr_idle_ack: got ready=%b overrun=%b want 0/0", rec_readyH, overrun_errH);
        end
        // Ack lands exactly on the stop-completion cycle of the next frame.
        sendFrame(8'h33, 1'b1, 1'b0);
        tgt = cyc + 2 + 153;
        fork
            sendFrame(8'h44, 1'b1, 1'b0);
            begin
                for (int k = 0; k < 400 && cyc != tgt; k++) @(negedge sys_clk);
                rec_ackH = 1'b1;
                @(negedge sys_clk);
                rec_ackH = 1'b0;
            end
        join
        tests++; if (rec_dataH !== 8'h44) begin fails++; $display("FAIL coll_data: got %h want 44", rec_dataH); end
        tests++; if (rec_readyH !== 1'b1) begin fails++; $display("FAIL coll_ready: got %b want 1", rec_readyH); end
        tests++; if (overrun_errH !== 1'b0) begin fails++; $display("FAIL coll_overrun: got %b want 0", overrun_errH); end
        pulseAck();
    endtask

    task automatic test_reset_midframe();
        int unsigned base;
        base = riseCount;
        fork
            sendFrame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (16 * 5 + 8) @(negedge sys_clk);
                sys_rst = 1'b1;
                repeat (2) @(negedge sys_clk);
                sys_rst = 1'b0;
            end
        join
        repeat (4) @(negedge sys_clk);
        tests++; if (riseCount !== base || rec_readyH !== 1'b0) begin
            fails++; $display("FAIL rst_abort: got rises=%0d ready=%b want 0/0", riseCount - base, rec_readyH);
        end
        tests++; if (rec_dataH !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", rec_dataH); end
        sendFrame(8'h5A, 1'b1, 1'b0);
        tests++; if (rec_dataH !== 8'h5A || rec_readyH !== 1'b1) begin
            fails++; $display("FAIL rst_next: got data=%h ready=%b want 5a/1", rec_dataH, rec_readyH);
        end
        pulseAck();
    endtask

    task automatic test_majority();
        logic [7:0] want;
`ifdef UART_MAJORITY_VOTE_EN
        want = 8'h00;
`else
        want = 8'hFF;
`endif
        sendFrame(8'h00, 1'b1, 1'b1);
        tests++; if (rec_dataH !== want) begin fails++; $display("FAIL spike_data: got %h want %h", rec_dataH, want); end
        tests++; if (frame_errH !== 1'b0) begin fails++; $display("FAIL spike_frame: got %b want 0", frame_errH); end
        pulseAck();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_majority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/u_rec.md
Name: u_rec

Overview:
- Asynchronous UART receiver; the receive end of the serial link whose transmit end is u_xmit.
- Oversamples the line pin 16x and recovers 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Presents each byte on a parallel port with a ready/ack handshake, plus framing and overrun status.
- Sits between the connector pin and the host-side data consumer.

Parameters:
- WORD_LEN, 8, data bits per frame.
- OVERSAMPLE, 16, sys_clk cycles per bit cell (sys_clk must be 16x baud).

Ports:
- sys_clk  input  1  system clock, 16x baud.
- sys_rst  input  1  reset; synchronous, active-high.
- uart_recH  input  1  serial line from connector; idles high; asynchronous to sys_clk.
- rec_ackH  input  1  consumer has taken rec_dataH; clears rec_readyH.
- rec_dataH  output  8  last received byte.
- rec_readyH  output  1  byte valid; held high until acknowledged.
- rec_busyH  output  1  frame in progress (state != r_IDLE).
- frame_errH  output  1  stop bit sampled low on the last frame.
- overrun_errH  output  1  byte completed while rec_readyH was still high; sticky.

Behaviour:
- Reset: all outputs 0. Sync flops = 1. State = r_IDLE. Counters = 0. Shift register = 0. Reset mid-frame aborts the frame silently: no rec_readyH.
- Input path: 2-flop synchronizer gives rx_s; 2-cycle latency.
- bitCell counter (5b): increments while enabled, otherwise clears to 0.
- bitCount (4b): cleared in r_IDLE.
- r_IDLE:
  - rx_s==0 -> r_CENTER, counter cleared.
- r_CENTER:
  - Count while rx_s==0.
  - rx_s==1 before counter==7: false start -> r_IDLE, no outputs change.
  - counter==7 with rx_s==0 -> r_WAIT.
- r_WAIT:
  - Count to 14 (15 cycles), then one cycle in r_SAMPLE; total 16 cycles per bit.
  - If bitCount==WORD_LEN, go to r_STOP instead of r_SAMPLE.
- r_SAMPLE:
  - Shift register shifts right; rx_s enters bit 7, so after 8 samples the first bit received is in bit 0.
  - bitCount++ -> r_WAIT.
- r_STOP (1 cycle, at stop-bit centre):
  - rec_dataH <= shift register.
  - frame_errH <= ~rx_s.
  - rec_readyH <= 1.
  - overrun_errH |= rec_readyH & ~rec_ackH.
  - Next: rx_s==1 -> r_IDLE; rx_s==0 -> r_BREAK.
- r_BREAK: wait for rx_s==1 -> r_IDLE. A held-low line is never taken as a new start.
- Handshake:
  - rec_ackH with rec_readyH high clears rec_readyH and overrun_errH next cycle.
  - Ack in the same cycle as r_STOP completion: new byte wins; rec_readyH stays 1; no overrun flagged.
  - Ack while rec_readyH low is ignored.
- rec_dataH and frame_errH hold until the next completed frame.
- Sampling latency: bit centre + 2 cycles (synchronizer). rec_readyH rises 1 cycle after r_STOP.
- Illegal state encoding -> r_IDLE.

Optional Feature:
- Macro: UART_MAJORITY_VOTE_EN.
- Defined: every data and stop bit decision is the 2-of-3 majority of rx_s at counter values 13, 14 and the sample cycle. Start validation in r_CENTER is unchanged.
- Undefined: single sample of rx_s in r_SAMPLE / r_STOP.
- Cycle timing is identical either way.

Decomposition:
- Shared package uart_pkg (also used by u_xmit):
  - Receiver state enum: r_IDLE, r_CENTER, r_WAIT, r_SAMPLE, r_STOP, r_BREAK.
  - Constants WORD_LEN, OVERSAMPLE, LO/HI.
- Sub-module u_rec_sync: 2-flop synchronizer, parameterised reset value (1), synchronous reset.

Test Plan:
- Frame 0xA5 at 16 cycles/bit, ack 3 cycles after ready -> rec_dataH=0xA5, rec_readyH rises 150..158 cycles after start edge, frame_errH=0, overrun_errH=0.
- Low glitch of 5 cycles on an idle line -> state returns to r_IDLE, rec_readyH stays 0, rec_busyH high for at most 8 cycles.
- Frame 0x3C with stop bit low, then line high -> rec_dataH=0x3C, frame_errH=1, passes through r_BREAK; following frame 0x81 received correctly with frame_errH=0.
- Back-to-back frames 0x11, 0x22 with no ack -> rec_dataH=0x22, overrun_errH=1; ack clears rec_readyH and overrun_errH.
- sys_rst asserted at bit 4 of frame 0xFF, released 2 cycles later, then frame 0x5A -> no ready for 0xFF; rec_dataH=0x5A.
- With UART_MAJORITY_VOTE_EN: frame 0x00 with a 1-cycle high spike at each bit centre -> rec_dataH=0x00; without the macro, affected bits read 1.
